// File: rtl/dram_arb_pkg.sv
// Shared types for the DRAM access arbiter: FSM state encoding and requester IDs.
package dram_arb_pkg;
  typedef enum logic [1:0] {IDLE, ISSUE, RD_WAIT, DONE} state_t;

  localparam logic REQ_CPU = 1'b0;
  localparam logic REQ_LD  = 1'b1;
endpackage

// File: rtl/dram_access_arbiter_rr_pick2.sv
// Combinational 2-way round-robin picker: on a tie, grant the requester not served last.
module rr_pick2
  import dram_arb_pkg::*;
(
  input  logic [1:0] req,
  input  logic       last,
  output logic       gnt_id,
  output logic       valid
);
  always_comb begin
    valid  = |req;
    gnt_id = REQ_CPU;
    if (req == 2'b11) gnt_id = ~last;
    else if (req[REQ_LD]) gnt_id = REQ_LD;
  end
endmodule

// File: rtl/dram_access_arbiter.sv
// Round-robin arbiter sharing one DRAM port between controller and loader, one access in flight.
// Define DRAM_ARB_BURST_EN to let the owner chain up to BURST_MAX accesses per grant.
module dram_access_arbiter
  import dram_arb_pkg::*;
#(
  parameter int ADDR_W    = 16,
  parameter int DATA_W    = 8,
  parameter int RD_LAT    = 2,
  parameter int BURST_MAX = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              cpu_req,
  input  logic              cpu_we,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [DATA_W-1:0] cpu_wdata,
  output logic              cpu_gnt,
  output logic              cpu_done,
  output logic [DATA_W-1:0] cpu_rdata,
  input  logic              ld_req,
  input  logic              ld_we,
  input  logic [ADDR_W-1:0] ld_addr,
  input  logic [DATA_W-1:0] ld_wdata,
  output logic              ld_gnt,
  output logic              ld_done,
  output logic [DATA_W-1:0] ld_rdata,
  output logic [ADDR_W-1:0] dram_addr,
  output logic [DATA_W-1:0] dram_wdata,
  output logic              dram_read,
  output logic              dram_write,
  input  logic [DATA_W-1:0] dram_rdata,
  output logic              busy
);
  localparam int LW = $clog2(RD_LAT + 1);

  state_t              state, state_nxt;
  logic                owner, we_q, last_served;
  logic [ADDR_W-1:0]   addr_q;
  logic [DATA_W-1:0]   wdata_q;
  logic [LW-1:0]       lat_cnt;
  logic                pick_id, pick_vld, load, sel, rd_last, on_port;

  rr_pick2 u_pick (
    .req    ({ld_req, cpu_req}),
    .last   (last_served),
    .gnt_id (pick_id),
    .valid  (pick_vld)
  );

`ifdef DRAM_ARB_BURST_EN
  localparam int BW = (BURST_MAX > 1) ? $clog2(BURST_MAX) : 1;
  logic [BW-1:0] burst_cnt;
  logic          own_req, burst_go;
  assign own_req  = (owner == REQ_LD) ? ld_req : cpu_req;
  assign burst_go = own_req && (burst_cnt < BW'(BURST_MAX - 1));
`endif

  // A burst re-latches the current owner in DONE; otherwise the picker decides in IDLE.
  assign sel     = (state == DONE) ? owner : pick_id;
  assign rd_last = !we_q && (((state == ISSUE) && (RD_LAT == 1)) ||
                             ((state == RD_WAIT) && (lat_cnt == LW'(RD_LAT - 1))));

  always_comb begin
    state_nxt = state;
    load      = 1'b0;
    case (state)
      IDLE:    if (pick_vld) begin state_nxt = ISSUE; load = 1'b1; end
      ISSUE:   state_nxt = (we_q || RD_LAT == 1) ? DONE : RD_WAIT;
      RD_WAIT: if (rd_last) state_nxt = DONE;
      DONE: begin
        state_nxt = IDLE;
`ifdef DRAM_ARB_BURST_EN
        if (burst_go) begin state_nxt = ISSUE; load = 1'b1; end
`endif
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      owner       <= REQ_CPU;
      we_q        <= 1'b0;
      addr_q      <= '0;
      wdata_q     <= '0;
      lat_cnt     <= '0;
      last_served <= REQ_LD;
      cpu_rdata   <= '0;
      ld_rdata    <= '0;
    end else begin
      state <= state_nxt;
      if (load) begin
        owner   <= sel;
        we_q    <= (sel == REQ_LD) ? ld_we    : cpu_we;
        addr_q  <= (sel == REQ_LD) ? ld_addr  : cpu_addr;
        wdata_q <= (sel == REQ_LD) ? ld_wdata : cpu_wdata;
      end
      if (state == ISSUE) lat_cnt <= LW'(1);
      else if (state == RD_WAIT) lat_cnt <= lat_cnt + LW'(1);
      if (rd_last) begin
        if (owner == REQ_LD) ld_rdata <= dram_rdata;
        else cpu_rdata <= dram_rdata;
      end
      if (state == DONE) last_served <= owner;
    end
  end

`ifdef DRAM_ARB_BURST_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) burst_cnt <= '0;
    else if (state == DONE) burst_cnt <= burst_go ? burst_cnt + BW'(1) : '0;
  end
`endif

  assign on_port    = (state == ISSUE) || (state == RD_WAIT);
  assign busy       = (state != IDLE);
  assign cpu_gnt    = busy && (owner == REQ_CPU);
  assign ld_gnt     = busy && (owner == REQ_LD);
  assign cpu_done   = (state == DONE) && (owner == REQ_CPU);
  assign ld_done    = (state == DONE) && (owner == REQ_LD);
  assign dram_write = (state == ISSUE) && we_q;
  assign dram_read  = on_port && !we_q;
  assign dram_addr  = on_port ? addr_q  : '0;
  assign dram_wdata = on_port ? wdata_q : '0;
endmodule

// File: tb/tb_dram_access_arbiter.sv
// Bench for dram_access_arbiter: directed scenarios plus random traffic against a timing-rule model.
module tb_dram_access_arbiter;
  localparam int RD_LAT = 2, BURST_MAX = 4;

  logic clk = 1'b0, rst_n;
  logic cpu_req, cpu_we, ld_req, ld_we;
  logic [15:0] cpu_addr, ld_addr, dram_addr;
  logic [7:0] cpu_wdata, ld_wdata, cpu_rdata, ld_rdata, dram_wdata, dram_rdata;
  logic cpu_gnt, cpu_done, ld_gnt, ld_done, dram_read, dram_write, busy;

  always #5 clk = ~clk;

  dram_access_arbiter #(.ADDR_W(16), .DATA_W(8), .RD_LAT(RD_LAT), .BURST_MAX(BURST_MAX)) dut (
    .clk(clk), .rst_n(rst_n),
    .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
    .cpu_gnt(cpu_gnt), .cpu_done(cpu_done), .cpu_rdata(cpu_rdata),
    .ld_req(ld_req), .ld_we(ld_we), .ld_addr(ld_addr), .ld_wdata(ld_wdata),
    .ld_gnt(ld_gnt), .ld_done(ld_done), .ld_rdata(ld_rdata),
    .dram_addr(dram_addr), .dram_wdata(dram_wdata), .dram_read(dram_read),
    .dram_write(dram_write), .dram_rdata(dram_rdata), .busy(busy)
  );

  int n_chk = 0, n_fail = 0;
  // requester shadows (index 0 = cpu, 1 = loader), applied once per cycle at the falling edge
  logic s_req[2], s_we[2];
  logic [15:0] s_addr[2];
  logic [7:0] s_wdata[2], s_rd;
  int keep[2];
  bit auto_md = 0;
  // transaction model: one access, decided at cycle t_dec, completing at t_done
  bit m_act, m_own, m_we, m_last;
  logic [15:0] m_addr;
  logic [7:0] m_wdata, exp_rd[2];
  int t_dec, t_done, m_burst, mc = 0;
  bit dn[2];
  int order[$];

  task automatic chk(string tag, logic [31:0] got, logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s cyc=%0d got=%0h exp=%0h", tag, mc, got, exp);
    end
  endtask

  task automatic model_reset();
    m_act = 0; m_last = 1; m_burst = 0; exp_rd[0] = 0; exp_rd[1] = 0;
    keep[0] = 0; keep[1] = 0;
  endtask

  task automatic start(bit o, int c);
    m_own = o; m_we = s_we[o]; m_addr = s_addr[o]; m_wdata = s_wdata[o];
    t_dec = c; t_done = c + (m_we ? 2 : RD_LAT + 1); m_act = 1;
  endtask

  task automatic compare();
    int c = mc;
    bit ia, mid;
    ia  = m_act && c > t_dec && c <= t_done;
    mid = m_act && c > t_dec && c < t_done;
    dn[0] = m_act && c == t_done && !m_own;
    dn[1] = m_act && c == t_done && m_own;
    chk("cpu_gnt", cpu_gnt, ia && !m_own);
    chk("ld_gnt", ld_gnt, ia && m_own);
    chk("cpu_done", cpu_done, dn[0]);
    chk("ld_done", ld_done, dn[1]);
    chk("busy", busy, ia);
    chk("dram_write", dram_write, mid && m_we && c == t_dec + 1);
    chk("dram_read", dram_read, mid && !m_we);
    chk("dram_addr", dram_addr, mid ? m_addr : 16'h0);
    chk("dram_wdata", dram_wdata, mid ? m_wdata : 8'h0);
    chk("cpu_rdata", cpu_rdata, exp_rd[0]);
    chk("ld_rdata", ld_rdata, exp_rd[1]);
  endtask

  task automatic stim();
    if (auto_md) s_rd = 8'($urandom);
    for (int o = 0; o < 2; o++) begin
      if (s_req[o] && dn[o]) begin
        if (auto_md ? ($urandom % 2 == 0) : (keep[o] == 0)) s_req[o] = 0;
        else begin
          if (!auto_md) keep[o]--;
          else begin
            s_we[o] = 1'($urandom); s_addr[o] = 16'($urandom); s_wdata[o] = 8'($urandom);
          end
        end
      end else if (!s_req[o] && auto_md && $urandom % 4 == 0) begin
        s_req[o] = 1; s_we[o] = 1'($urandom); s_addr[o] = 16'($urandom); s_wdata[o] = 8'($urandom);
      end
    end
    cpu_req = s_req[0]; cpu_we = s_we[0]; cpu_addr = s_addr[0]; cpu_wdata = s_wdata[0];
    ld_req = s_req[1]; ld_we = s_we[1]; ld_addr = s_addr[1]; ld_wdata = s_wdata[1];
    dram_rdata = s_rd;
  endtask

  task automatic update();
    int c = mc;
    if (m_act && !m_we && c == t_dec + RD_LAT) exp_rd[m_own] = dram_rdata;
    if (m_act && c == t_done) begin
      m_last = m_own;
`ifdef DRAM_ARB_BURST_EN
      if (s_req[m_own] && m_burst < BURST_MAX - 1) begin m_burst++; start(m_own, c); end
      else begin m_act = 0; m_burst = 0; end
`else
      m_act = 0;
`endif
    end else if (!m_act && (s_req[0] || s_req[1])) begin
      start((s_req[0] && s_req[1]) ? !m_last : s_req[1], c);
    end
  endtask

  task automatic tick(int n = 1);
    repeat (n) begin
      @(negedge clk);
      compare();
      if (cpu_done === 1'b1) order.push_back(0);
      if (ld_done === 1'b1) order.push_back(1);
      stim();
      update();
      mc++;
    end
  endtask

  task automatic set_req(int o, bit we, logic [15:0] a, logic [7:0] d, int k);
    s_req[o] = 1; s_we[o] = we; s_addr[o] = a; s_wdata[o] = d; keep[o] = k;
  endtask

  task automatic chk_order(string tag, int exp_q[$]);
    chk({tag, "_len"}, (order.size() >= exp_q.size()), 1);
    for (int i = 0; i < exp_q.size() && i < order.size(); i++) chk(tag, order[i], exp_q[i]);
  endtask

  initial begin
    rst_n = 0; s_rd = 0;
    for (int o = 0; o < 2; o++) begin s_req[o] = 0; s_we[o] = 0; s_addr[o] = 0; s_wdata[o] = 0; end
    model_reset();
    tick(2);
    rst_n = 1;
    tick(2);

    // both requesters after reset: cpu first, then round-robin (or bursts)
    order.delete();
    set_req(0, 1, 16'h0100, 8'h11, 3); set_req(1, 1, 16'h0200, 8'h22, 3);
    tick(40);
`ifdef DRAM_ARB_BURST_EN
    chk_order("tie_order", '{0, 0, 0, 0, 1, 1, 1, 1});
`else
    chk_order("tie_order", '{0, 1, 0, 1, 0, 1, 0, 1});
`endif

    // single cpu write
    set_req(0, 1, 16'h0010, 8'hA5, 0);
    tick(2);
    chk("t1_write", dram_write, 1); chk("t1_addr", dram_addr, 16'h0010); chk("t1_wdata", dram_wdata, 8'hA5);
    tick();
    chk("t1_done", cpu_done, 1);
    tick(3);

    // single cpu read
    s_rd = 8'h3C;
    set_req(0, 0, 16'h0020, 8'h00, 0);
    tick(2); chk("t2_rd1", dram_read, 1);
    tick();  chk("t2_rd2", dram_read, 1);
    tick();  chk("t2_done", cpu_done, 1); chk("t2_rdata", cpu_rdata, 8'h3C);
    s_rd = 8'h55;
    tick(3); chk("t2_hold", cpu_rdata, 8'h3C);

    // loader holds 6 writes while cpu also requests
    order.delete();
    set_req(1, 1, 16'h0300, 8'h77, 5);
    tick();
    set_req(0, 1, 16'h0400, 8'h88, 0);
    tick(40);
`ifdef DRAM_ARB_BURST_EN
    chk_order("ld_burst", '{1, 1, 1, 1, 0, 1, 1});
`else
    chk_order("ld_burst", '{1, 0, 1, 1, 1, 1, 1});
`endif

    // reset in the issue cycle of a loader read aborts it
    set_req(1, 0, 16'h0500, 8'h00, 0);
    tick(2);
    chk("t4_pre_read", dram_read, 1);
    #1 rst_n = 0;
    #1;
    chk("t4_read_drop", dram_read, 0); chk("t4_gnt_drop", ld_gnt, 0); chk("t4_busy", busy, 0);
    s_req[1] = 0;
    model_reset();
    tick(2);
    rst_n = 1;
    tick(4);

    // random traffic
    auto_md = 1;
    tick(3000);
    auto_md = 0;
    s_req[0] = 0; s_req[1] = 0;
    tick(10);

    $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
    $finish;
  end
endmodule
